rd_arb: RTL and testbench

RD_ARB -- requirements
Module: rd_arb

---
 rtl/rd_arb_pkg.sv | 13 +
 rtl/rd_arb_tag_fifo.sv | 68 ++++++
 rtl/rd_arb.sv | 135 +++++++++++++
 tb/tb_rd_arb.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_arb_pkg.sv
// Shared definitions for the read arbiter.
//   GNT_W / GNT_F : grant-id encoding, also stored as the tag of each outstanding read
//   OST_DEPTH_DEF : default number of outstanding memory reads
package rd_arb_pkg;

    localparam int unsigned OST_DEPTH_DEF = 4;

    typedef enum logic {
        GNT_W = 1'b0,
        GNT_F = 1'b1
    } gnt_e;

endpackage

// File: rtl/rd_arb_tag_fifo.sv
// Tag FIFO: remembers which requester issued each outstanding memory read so in-order
// responses can be routed back.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push, din       : write request and data (ignored while full, even with a pop)
//   pop, dout       : read request (ignored while empty), head of queue
//   full, empty     : occupancy flags
module tag_fifo #(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] din,
    input  logic             pop,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW:0]   FullCnt = (PtrW + 1)'(Depth);
    localparam logic [PtrW:0]   CntOne  = 1;
    localparam logic [PtrW-1:0] PtrOne  = 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == FullCnt);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rd_arb.sv
// Read arbiter: merges weight (W) and feature-map (F) read requests onto one memory
// port with round-robin tie breaking, and routes in-order memory responses back using
// a tag FIFO of outstanding grant ids.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   weight_biu2arb_* / fmap_*     : requester request channels (addr/vld in, rdy out)
//   arb2weight_biu_* / arb2fmap_* : requester response channels (addr/data/vld out, rdy in)
//   arb2mem_*                     : memory read-request channel
//   mem2arb_*                     : memory read-response channel (in request order)
//   arb_err                       : sticky, set by a response with nothing outstanding
module rd_arb
    import rd_arb_pkg::*;
#(
    parameter int unsigned OST_DEPTH = OST_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] weight_biu2arb_addr,
    input  logic        weight_biu2arb_vld,
    output logic        weight_biu2arb_rdy,
    output logic [31:0] arb2weight_biu_addr,
    output logic [31:0] arb2weight_biu_data,
    output logic        arb2weight_biu_vld,
    input  logic        arb2weight_biu_rdy,

    input  logic [31:0] fmap_biu2arb_addr,
    input  logic        fmap_biu2arb_vld,
    output logic        fmap_biu2arb_rdy,
    output logic [31:0] arb2fmap_biu_addr,
    output logic [31:0] arb2fmap_biu_data,
    output logic        arb2fmap_biu_vld,
    input  logic        arb2fmap_biu_rdy,

    output logic [31:0] arb2mem_addr,
    output logic        arb2mem_vld,
    input  logic        arb2mem_rdy,

    input  logic [31:0] mem2arb_addr,
    input  logic [31:0] mem2arb_data,
    input  logic        mem2arb_vld,
    output logic        mem2arb_rdy,

    output logic        arb_err
);

    gnt_e last_grant_q;
    gnt_e lock_id_q;
    logic lock_q;
    logic arb_err_q;
    gnt_e gnt;
    logic req_any;
    logic req_ok;
    logic push;
    logic pop;
    logic tag_in;
    logic tag_head;
    logic tag_full;
    logic tag_empty;
    logic head_is_f;
    logic resp_rdy_sel;
    logic lock_vld;

    // ---------------- request side ----------------
    assign req_any  = weight_biu2arb_vld || fmap_biu2arb_vld;
    assign lock_vld = (lock_id_q == GNT_F) ? fmap_biu2arb_vld : weight_biu2arb_vld;

    // A grant left pending under backpressure is pinned until accepted or its vld drops.
    always_comb begin
        gnt = GNT_W;
        if (lock_q && lock_vld) begin
            gnt = lock_id_q;
        end else if (weight_biu2arb_vld && fmap_biu2arb_vld) begin
            gnt = (last_grant_q == GNT_F) ? GNT_W : GNT_F;
        end else if (fmap_biu2arb_vld) begin
            gnt = GNT_F;
        end
    end

    assign req_ok             = !rst && arb2mem_rdy && !tag_full;
    assign arb2mem_vld        = !rst && req_any && !tag_full;
    assign arb2mem_addr       = (gnt == GNT_F) ? fmap_biu2arb_addr : weight_biu2arb_addr;
    assign weight_biu2arb_rdy = req_ok && (gnt == GNT_W);
    assign fmap_biu2arb_rdy   = req_ok && (gnt == GNT_F);
    assign push               = arb2mem_vld && arb2mem_rdy;
    assign tag_in             = (gnt == GNT_F);

    // ---------------- response side ----------------
    assign head_is_f    = (tag_head == 1'b1);
    assign resp_rdy_sel = head_is_f ? arb2fmap_biu_rdy : arb2weight_biu_rdy;
    assign mem2arb_rdy  = !rst && !tag_empty && resp_rdy_sel;
    assign pop          = mem2arb_vld && mem2arb_rdy;

    assign arb2weight_biu_vld  = !rst && !tag_empty && mem2arb_vld && !head_is_f;
    assign arb2fmap_biu_vld    = !rst && !tag_empty && mem2arb_vld && head_is_f;
    assign arb2weight_biu_addr = mem2arb_addr;
    assign arb2weight_biu_data = mem2arb_data;
    assign arb2fmap_biu_addr   = mem2arb_addr;
    assign arb2fmap_biu_data   = mem2arb_data;

    assign arb_err = arb_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GNT_F;
            lock_q       <= 1'b0;
            lock_id_q    <= GNT_W;
            arb_err_q    <= 1'b0;
        end else begin
            if (push) begin
                last_grant_q <= gnt;
            end
            lock_q    <= req_any && !push;
            lock_id_q <= gnt;
            if (mem2arb_vld && tag_empty) begin
                arb_err_q <= 1'b1;
            end
        end
    end

    tag_fifo #(
        .Width (1),
        .Depth (OST_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (tag_in),
        .pop   (pop),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

endmodule

// File: tb/tb_rd_arb.sv
module tb_rd_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] w_addr;
    logic        w_vld;
    logic        w_rdy;
    logic [31:0] rw_addr;
    logic [31:0] rw_data;
    logic        rw_vld;
    logic        rw_rdy;
    logic [31:0] f_addr;
    logic        f_vld;
    logic        f_rdy;
    logic [31:0] rf_addr;
    logic [31:0] rf_data;
    logic        rf_vld;
    logic        rf_rdy;
    logic [31:0] m_addr;
    logic        m_vld;
    logic        m_rdy;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_vld;
    logic        r_rdy;
    logic        err;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] WA = 32'h0000_1000;
    localparam logic [31:0] FA = 32'h0000_2000;

    always #5 clk = ~clk;

    rd_arb #(.OST_DEPTH(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .weight_biu2arb_addr (w_addr),
        .weight_biu2arb_vld  (w_vld),
        .weight_biu2arb_rdy  (w_rdy),
        .arb2weight_biu_addr (rw_addr),
        .arb2weight_biu_data (rw_data),
        .arb2weight_biu_vld  (rw_vld),
        .arb2weight_biu_rdy  (rw_rdy),
        .fmap_biu2arb_addr   (f_addr),
        .fmap_biu2arb_vld    (f_vld),
        .fmap_biu2arb_rdy    (f_rdy),
        .arb2fmap_biu_addr   (rf_addr),
        .arb2fmap_biu_data   (rf_data),
        .arb2fmap_biu_vld    (rf_vld),
        .arb2fmap_biu_rdy    (rf_rdy),
        .arb2mem_addr        (m_addr),
        .arb2mem_vld         (m_vld),
        .arb2mem_rdy         (m_rdy),
        .mem2arb_addr        (r_addr),
        .mem2arb_data        (r_data),
        .mem2arb_vld         (r_vld),
        .mem2arb_rdy         (r_rdy),
        .arb_err             (err)
    );

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_vld = 1'b0; w_addr = WA;
        f_vld = 1'b0; f_addr = FA;
        m_rdy = 1'b0;
        r_vld = 1'b0; r_addr = '0; r_data = '0;
        rw_rdy = 1'b0; rf_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        w_vld = 1'b1; f_vld = 1'b1; m_rdy = 1'b1;
        r_vld = 1'b1; rw_rdy = 1'b1; rf_rdy = 1'b1;
        tick(); tick();
        #1;
        checks++;
        if ({m_vld, w_rdy, f_rdy, r_rdy, rw_vld, rf_vld} !== 6'b0) begin
            failures++;
            $display("FAIL reset_handshakes got=%b exp=000000",
                     {m_vld, w_rdy, f_rdy, r_rdy, rw_vld, rf_vld});
        end
        checks++;
        if (err !== 1'b0) begin
            failures++; $display("FAIL reset_err got=%b exp=0", err);
        end
        idle();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (err !== 1'b0) begin
            failures++; $display("FAIL reset_err_after got=%b exp=0", err);
        end
    endtask

    task automatic test_w_only();
        w_vld = 1'b1; w_addr = 32'h100; m_rdy = 1'b1;
        #1;
        checks++;
        if (m_vld !== 1'b1 || m_addr !== 32'h100) begin
            failures++;
            $display("FAIL w_only_req got vld=%b addr=%h exp vld=1 addr=00000100", m_vld, m_addr);
        end
        checks++;
        if (w_rdy !== 1'b1 || f_rdy !== 1'b0) begin
            failures++; $display("FAIL w_only_rdy got w=%b f=%b exp w=1 f=0", w_rdy, f_rdy);
        end
        tick();
        idle();
        r_vld = 1'b1; r_addr = 32'h100; r_data = 32'hDEADBEEF; rw_rdy = 1'b1; rf_rdy = 1'b1;
        #1;
        checks++;
        if (rw_vld !== 1'b1 || rf_vld !== 1'b0 || rw_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL w_only_resp got wv=%b fv=%b data=%h exp wv=1 fv=0 data=deadbeef",
                     rw_vld, rf_vld, rw_data);
        end
        checks++;
        if (r_rdy !== 1'b1) begin
            failures++; $display("FAIL w_only_resp_rdy got=%b exp=1", r_rdy);
        end
        tick();
        idle();
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr [4];
        logic        exp_f [4];
        exp_addr[0] = WA; exp_addr[1] = FA; exp_addr[2] = WA; exp_addr[3] = FA;
        exp_f[0] = 1'b0; exp_f[1] = 1'b1; exp_f[2] = 1'b0; exp_f[3] = 1'b1;
        rst = 1'b1; idle(); tick(); rst = 1'b0;
        w_vld = 1'b1; f_vld = 1'b1; m_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (m_addr !== exp_addr[i] || m_vld !== 1'b1) begin
                failures++;
                $display("FAIL rr_grant%0d got addr=%h vld=%b exp addr=%h vld=1",
                         i, m_addr, m_vld, exp_addr[i]);
            end
            tick();
        end
        idle();
        r_vld = 1'b1; rw_rdy = 1'b1; rf_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            r_data = 32'hA0 + i;
            #1;
            checks++;
            if (rw_vld !== !exp_f[i] || rf_vld !== exp_f[i]) begin
                failures++;
                $display("FAIL rr_route%0d got wv=%b fv=%b exp wv=%b fv=%b",
                         i, rw_vld, rf_vld, !exp_f[i], exp_f[i]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_full();
        w_vld = 1'b1; m_rdy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (w_rdy !== 1'b0 || m_vld !== 1'b0) begin
            failures++;
            $display("FAIL full_block got rdy=%b mvld=%b exp rdy=0 mvld=0", w_rdy, m_vld);
        end
        r_vld = 1'b1; rw_rdy = 1'b1;
        #1;
        checks++;
        if (r_rdy !== 1'b1) begin
            failures++; $display("FAIL full_resp_rdy got=%b exp=1", r_rdy);
        end
        tick();
        r_vld = 1'b0;
        #1;
        checks++;
        if (w_rdy !== 1'b1 || m_vld !== 1'b1) begin
            failures++;
            $display("FAIL full_one_slot got rdy=%b mvld=%b exp rdy=1 mvld=1", w_rdy, m_vld);
        end
        tick();
        checks++;
        if (w_rdy !== 1'b0 || m_vld !== 1'b0) begin
            failures++;
            $display("FAIL full_again got rdy=%b mvld=%b exp rdy=0 mvld=0", w_rdy, m_vld);
        end
        idle();
        r_vld = 1'b1; rw_rdy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        idle();
    endtask

    task automatic test_stall();
        // Issue W, F, F, W one at a time.
        m_rdy = 1'b1;
        w_vld = 1'b1; tick();
        w_vld = 1'b0; f_vld = 1'b1; tick();
        tick();
        f_vld = 1'b0; w_vld = 1'b1; tick();
        idle();
        r_vld = 1'b1; rw_rdy = 1'b1; rf_rdy = 1'b0; r_data = 32'h11;
        #1;
        checks++;
        if (rw_vld !== 1'b1 || r_rdy !== 1'b1) begin
            failures++; $display("FAIL stall_first_w got wv=%b rdy=%b exp 1 1", rw_vld, r_rdy);
        end
        tick();
        r_data = 32'h22;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (r_rdy !== 1'b0 || rf_vld !== 1'b1 || rw_vld !== 1'b0) begin
                failures++;
                $display("FAIL stall_cyc%0d got rdy=%b fv=%b wv=%b exp rdy=0 fv=1 wv=0",
                         i, r_rdy, rf_vld, rw_vld);
            end
            tick();
        end
        rf_rdy = 1'b1;
        #1;
        checks++;
        if (r_rdy !== 1'b1 || rf_data !== 32'h22) begin
            failures++;
            $display("FAIL stall_release got rdy=%b data=%h exp rdy=1 data=00000022", r_rdy, rf_data);
        end
        tick();
        r_data = 32'h33;
        #1;
        checks++;
        if (rf_vld !== 1'b1 || rw_vld !== 1'b0) begin
            failures++; $display("FAIL stall_second_f got fv=%b wv=%b exp 1 0", rf_vld, rw_vld);
        end
        tick();
        r_data = 32'h44;
        #1;
        checks++;
        if (rw_vld !== 1'b1 || rf_vld !== 1'b0 || rw_data !== 32'h44) begin
            failures++;
            $display("FAIL stall_last_w got wv=%b fv=%b data=%h exp 1 0 00000044",
                     rw_vld, rf_vld, rw_data);
        end
        tick();
        idle();
    endtask

    task automatic test_err();
        r_vld = 1'b1; rw_rdy = 1'b1; rf_rdy = 1'b1;
        #1;
        checks++;
        if (r_rdy !== 1'b0 || rw_vld !== 1'b0 || rf_vld !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL err_empty got rdy=%b wv=%b fv=%b err=%b exp 0 0 0 0",
                     r_rdy, rw_vld, rf_vld, err);
        end
        tick();
        idle();
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL err_set got=%b exp=1", err);
        end
        tick(); tick(); tick();
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL err_sticky got=%b exp=1", err);
        end
    endtask

    task automatic test_reset_mid();
        // Two W grants leave last_grant=W; reset must restore W priority.
        w_vld = 1'b1; m_rdy = 1'b1;
        tick(); tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rw_rdy = 1'b1; rf_rdy = 1'b1;
        #1;
        checks++;
        if (err !== 1'b0 || r_rdy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_clear got err=%b rdy=%b exp err=0 rdy=0", err, r_rdy);
        end
        w_vld = 1'b1; f_vld = 1'b1; m_rdy = 1'b1;
        #1;
        checks++;
        if (m_addr !== WA || w_rdy !== 1'b1 || f_rdy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_tie got addr=%h w=%b f=%b exp addr=%h w=1 f=0",
                     m_addr, w_rdy, f_rdy, WA);
        end
        w_vld = 1'b0; f_vld = 1'b0;
        r_vld = 1'b1;
        tick();
        r_vld = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            failures++; $display("FAIL rstmid_stale_resp got err=%b exp=1", err);
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_w_only();
        test_round_robin();
        test_full();
        test_stall();
        test_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
